// File: rtl/dtw_trace_ctrl.sv
// DTW fill/traceback sequencer: sweeps cell indices to the score-unit array,
// kicks the traceback chain and streams the path bus into the result SRAM.
//
// Ports:
//   clk, nrst                 clock, async active-low reset
//   i_start/i_abort           host start pulse, synchronous abort
//   i_tlen/i_rlen             template/reference lengths (1..30)
//   o_cell_vld/i_cell_rdy     cell index handshake with distance datapath
//   o_tindex/o_rindex         broadcast cell indices (IDX_INV when idle)
//   o_outena_last             traceback kick to the final unit
//   i_chain_vld/i_bus         shared path bus and its drive indicator
//   o_sram_we/addr/wdata      result SRAM write port
//   o_busy/o_done/o_err/o_len host status
module dtw_trace_ctrl #(
  parameter int ADDR_W = 6,
  parameter logic [4:0] IDX_INV = 5'd31
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [4:0]        i_tlen,
  input  logic [4:0]        i_rlen,
  output logic              o_cell_vld,
  input  logic              i_cell_rdy,
  output logic [4:0]        o_tindex,
  output logic [4:0]        o_rindex,
  output logic              o_outena_last,
  input  logic              i_chain_vld,
  input  logic [31:0]       i_bus,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_len
);

  typedef enum logic [2:0] {
    IDLE, FILL, DRAIN, KICK, TRACE, FIN
  } state_t;

  state_t            state;
  logic [4:0]        tlen;
  logic [4:0]        rlen;
  logic [ADDR_W-1:0] addr;

  logic trace_ph;
  logic word_00;
  logic addr_last;
  logic len_bad;
  logic last_r;
  logic last_t;

  assign trace_ph  = (state == KICK) || (state == TRACE);
  assign word_00   = (i_bus[28:24] == 5'd0) && (i_bus[20:16] == 5'd0);
  assign addr_last = &addr;
  assign len_bad   = (i_tlen == 5'd0) || (i_tlen == 5'd31) ||
                     (i_rlen == 5'd0) || (i_rlen == 5'd31);
  assign last_r    = (o_rindex == rlen - 5'd1);
  assign last_t    = (o_tindex == tlen - 5'd1);

  // The bus word only exists in its drive cycle, so the write port
  // is combinational; abort kills the strobe in the same cycle.
  assign o_sram_we    = trace_ph & i_chain_vld & ~i_abort;
  assign o_sram_addr  = addr;
  assign o_sram_wdata = i_bus;

  // In FILL the registered index outputs double as the (t, r) counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      tlen          <= 5'd0;
      rlen          <= 5'd0;
      addr          <= '0;
      o_cell_vld    <= 1'b0;
      o_tindex      <= IDX_INV;
      o_rindex      <= IDX_INV;
      o_outena_last <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_len         <= '0;
    end else begin
      o_done        <= 1'b0;
      o_outena_last <= 1'b0;
      if (i_abort) begin
        state      <= IDLE;
        o_cell_vld <= 1'b0;
        o_tindex   <= IDX_INV;
        o_rindex   <= IDX_INV;
        o_busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_start) begin
              tlen   <= i_tlen;
              rlen   <= i_rlen;
              addr   <= '0;
              o_len  <= '0;
              o_err  <= 1'b0;
              o_busy <= 1'b1;
              if (len_bad) begin
                o_err  <= 1'b1;
                o_done <= 1'b1;
                state  <= FIN;
              end else begin
                o_cell_vld <= 1'b1;
                o_tindex   <= 5'd0;
                o_rindex   <= 5'd0;
                state      <= FILL;
              end
            end
          end
          FILL: begin
            if (i_cell_rdy) begin
              if (last_r && last_t) begin
                o_cell_vld <= 1'b0;
                o_tindex   <= IDX_INV;
                o_rindex   <= IDX_INV;
                state      <= DRAIN;
              end else if (last_r) begin
                o_rindex <= 5'd0;
                o_tindex <= o_tindex + 5'd1;
              end else begin
                o_rindex <= o_rindex + 5'd1;
              end
            end
          end
          DRAIN: begin
            o_outena_last <= 1'b1;
            state         <= KICK;
          end
          KICK, TRACE: begin
            if (i_chain_vld) begin
              addr  <= addr + ADDR_W'(1);
              o_len <= o_len + (ADDR_W+1)'(1);
              if (word_00) begin
                o_done <= 1'b1;
                state  <= FIN;
              end else if (addr_last) begin
                o_err  <= 1'b1;
                o_done <= 1'b1;
                state  <= FIN;
              end else begin
                state <= TRACE;
              end
            end else if (state == TRACE) begin
              o_err  <= 1'b1;
              o_done <= 1'b1;
              state  <= FIN;
            end else begin
              state <= TRACE;
            end
          end
          FIN: begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dtw_trace_ctrl.sv
// Directed bench for dtw_trace_ctrl: default instance plus an
// ADDR_W=2 instance sharing the same stimulus for buffer overflow.
module tb_dtw_trace_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [4:0]  i_tlen = 5'd0;
  logic [4:0]  i_rlen = 5'd0;
  logic        i_cell_rdy = 1'b0;
  logic        i_chain_vld = 1'b0;
  logic [31:0] i_bus = 32'd0;

  logic        cell_vld, outena, we, busy, done, err;
  logic [4:0]  tidx, ridx;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [6:0]  len;

  logic        b_cell_vld, b_outena, b_we, b_busy, b_done, b_err;
  logic [4:0]  b_tidx, b_ridx;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dtw_trace_ctrl dut (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_abort(i_abort),
    .i_tlen(i_tlen), .i_rlen(i_rlen), .o_cell_vld(cell_vld),
    .i_cell_rdy(i_cell_rdy), .o_tindex(tidx), .o_rindex(ridx),
    .o_outena_last(outena), .i_chain_vld(i_chain_vld), .i_bus(i_bus),
    .o_sram_we(we), .o_sram_addr(addr), .o_sram_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_len(len)
  );

  dtw_trace_ctrl #(.ADDR_W(2)) dut_b (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_abort(i_abort),
    .i_tlen(i_tlen), .i_rlen(i_rlen), .o_cell_vld(b_cell_vld),
    .i_cell_rdy(i_cell_rdy), .o_tindex(b_tidx), .o_rindex(b_ridx),
    .o_outena_last(b_outena), .i_chain_vld(i_chain_vld), .i_bus(i_bus),
    .o_sram_we(b_we), .o_sram_addr(b_addr), .o_sram_wdata(b_wdata),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_len(b_len)
  );

  function automatic logic [31:0] mk(input logic [4:0] t,
                                     input logic [4:0] r,
                                     input logic [15:0] d);
    return {3'b0, t, 3'b0, r, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] t, input logic [4:0] r);
    i_start = 1'b1;
    i_tlen  = t;
    i_rlen  = r;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (tidx !== 5'd31 || ridx !== 5'd31) begin fails++;
      $display("FAIL reset_idx: got %0d,%0d want 31,31", tidx, ridx); end
    tests++; if ({cell_vld, outena, we, done, err, busy} !== 6'b0) begin fails++;
      $display("FAIL reset_flags: got %b want 000000",
               {cell_vld, outena, we, done, err, busy}); end
    tests++; if (addr !== 6'd0 || len !== 7'd0) begin fails++;
      $display("FAIL reset_addr_len: got %0d,%0d want 0,0", addr, len); end
    nrst = 1'b1;
    tick();
    tests++; if (busy !== 1'b0 || cell_vld !== 1'b0) begin fails++;
      $display("FAIL idle_after_reset: got busy=%b vld=%b want 0,0", busy, cell_vld); end
  endtask

  task automatic test_diag;
    logic [4:0] et [4];
    logic [4:0] er [4];
    et = '{0, 0, 1, 1};
    er = '{0, 1, 0, 1};
    start(5'd2, 5'd2);
    i_cell_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (cell_vld !== 1'b1 || tidx !== et[i] || ridx !== er[i]) begin fails++;
        $display("FAIL diag_cell%0d: got vld=%b %0d,%0d want 1 %0d,%0d",
                 i, cell_vld, tidx, ridx, et[i], er[i]); end
      tick();
    end
    i_cell_rdy = 1'b0;
    tests++; if (cell_vld !== 1'b0 || tidx !== 5'd31 || outena !== 1'b0) begin fails++;
      $display("FAIL diag_drain: got vld=%b t=%0d kick=%b want 0 31 0", cell_vld, tidx, outena); end
    tick();
    tests++; if (outena !== 1'b1) begin fails++;
      $display("FAIL diag_kick: got %b want 1", outena); end
    i_chain_vld = 1'b1;
    i_bus = mk(5'd1, 5'd1, 16'h0005);
    #1;
    tests++; if (we !== 1'b1 || addr !== 6'd0 || wdata !== mk(5'd1, 5'd1, 16'h0005)) begin fails++;
      $display("FAIL diag_w0: got we=%b a=%0d d=%h want 1 0 %h", we, addr, wdata, mk(5'd1, 5'd1, 16'h0005)); end
    tick();
    i_bus = mk(5'd0, 5'd0, 16'h0002);
    #1;
    tests++; if (we !== 1'b1 || addr !== 6'd1 || outena !== 1'b0) begin fails++;
      $display("FAIL diag_w1: got we=%b a=%0d kick=%b want 1 1 0", we, addr, outena); end
    tick();
    i_chain_vld = 1'b0;
    #1;
    tests++; if (done !== 1'b1 || len !== 7'd2 || err !== 1'b0 || we !== 1'b0) begin fails++;
      $display("FAIL diag_done: got done=%b len=%0d err=%b we=%b want 1 2 0 0", done, len, err, we); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL diag_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    int mt, mr, acc;
    pat = 4'b1001;
    mt = 0; mr = 0; acc = 0;
    start(5'd3, 5'd4);
    for (int cyc = 0; cyc < 60 && acc < 12; cyc++) begin
      i_cell_rdy = pat[cyc % 4];
      tests++; if (cell_vld !== 1'b1 || tidx !== 5'(mt) || ridx !== 5'(mr)) begin fails++;
        $display("FAIL bp_cyc%0d: got vld=%b %0d,%0d want 1 %0d,%0d",
                 cyc, cell_vld, tidx, ridx, mt, mr); end
      if (i_cell_rdy) begin
        acc++;
        if (mr == 3) begin mr = 0; mt++; end
        else mr++;
      end
      tick();
    end
    i_cell_rdy = 1'b0;
    tests++; if (acc !== 12) begin fails++;
      $display("FAIL bp_count: got %0d want 12", acc); end
    tests++; if (cell_vld !== 1'b0 || ridx !== 5'd31) begin fails++;
      $display("FAIL bp_drain: got vld=%b r=%0d want 0 31", cell_vld, ridx); end
    tick();
    i_chain_vld = 1'b1;
    i_bus = mk(5'd0, 5'd0, 16'h0000);
    tick();
    i_chain_vld = 1'b0;
    tests++; if (done !== 1'b1 || len !== 7'd1) begin fails++;
      $display("FAIL bp_done: got done=%b len=%0d want 1 1", done, len); end
    tick();
  endtask

  task automatic test_broken_chain;
    start(5'd3, 5'd3);
    i_cell_rdy = 1'b1;
    repeat (9) tick();
    i_cell_rdy = 1'b0;
    tick();
    i_chain_vld = 1'b1;
    i_bus = mk(5'd2, 5'd2, 16'h0009);
    tick();
    i_bus = mk(5'd2, 5'd1, 16'h0007);
    tick();
    i_chain_vld = 1'b0;
    i_bus = mk(5'd1, 5'd1, 16'h0004);
    #1;
    tests++; if (we !== 1'b0) begin fails++;
      $display("FAIL broken_we: got %b want 0", we); end
    tick();
    tests++; if (done !== 1'b1 || err !== 1'b1 || len !== 7'd2) begin fails++;
      $display("FAIL broken_done: got done=%b err=%b len=%0d want 1 1 2", done, err, len); end
    tick();
    tests++; if (err !== 1'b1 || done !== 1'b0) begin fails++;
      $display("FAIL broken_err_hold: got err=%b done=%b want 1 0", err, done); end
  endtask

  task automatic test_overflow;
    logic [31:0] w [5];
    w[0] = mk(5'd2, 5'd2, 16'd5);
    w[1] = mk(5'd2, 5'd1, 16'd4);
    w[2] = mk(5'd1, 5'd1, 16'd3);
    w[3] = mk(5'd1, 5'd0, 16'd2);
    w[4] = mk(5'd0, 5'd0, 16'd1);
    start(5'd3, 5'd3);
    i_cell_rdy = 1'b1;
    repeat (9) tick();
    i_cell_rdy = 1'b0;
    tick();
    i_chain_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_bus = w[i];
      #1;
      tests++; if (b_we !== 1'b1 || b_addr !== 2'(i) || we !== 1'b1 || addr !== 6'(i)) begin fails++;
        $display("FAIL ovf_w%0d: got bwe=%b ba=%0d we=%b a=%0d want 1 %0d 1 %0d",
                 i, b_we, b_addr, we, addr, i, i); end
      tick();
    end
    i_bus = w[4];
    #1;
    tests++; if (b_we !== 1'b0 || b_done !== 1'b1 || b_err !== 1'b1 || b_len !== 3'd4) begin fails++;
      $display("FAIL ovf_b_done: got we=%b done=%b err=%b len=%0d want 0 1 1 4",
               b_we, b_done, b_err, b_len); end
    tests++; if (we !== 1'b1 || addr !== 6'd4 || err !== 1'b0) begin fails++;
      $display("FAIL ovf_a_w4: got we=%b a=%0d err=%b want 1 4 0", we, addr, err); end
    tick();
    i_chain_vld = 1'b0;
    tests++; if (done !== 1'b1 || err !== 1'b0 || len !== 7'd5 || b_done !== 1'b0) begin fails++;
      $display("FAIL ovf_a_done: got done=%b err=%b len=%0d bdone=%b want 1 0 5 0",
               done, err, len, b_done); end
    tick();
  endtask

  task automatic test_abort;
    start(5'd3, 5'd3);
    i_cell_rdy = 1'b1;
    repeat (2) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_cell_rdy = 1'b0;
    tests++; if (cell_vld !== 1'b0 || tidx !== 5'd31 || ridx !== 5'd31 || busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL abort_fill: got vld=%b %0d,%0d busy=%b done=%b want 0 31,31 0 0",
               cell_vld, tidx, ridx, busy, done); end
    tick();
    tests++; if (done !== 1'b0 || cell_vld !== 1'b0) begin fails++;
      $display("FAIL abort_fill_after: got done=%b vld=%b want 0 0", done, cell_vld); end
    start(5'd2, 5'd2);
    i_cell_rdy = 1'b1;
    repeat (4) tick();
    i_cell_rdy = 1'b0;
    tick();
    i_chain_vld = 1'b1;
    i_bus = mk(5'd1, 5'd1, 16'd3);
    tick();
    i_bus = mk(5'd0, 5'd1, 16'd2);
    i_abort = 1'b1;
    #1;
    tests++; if (we !== 1'b0) begin fails++;
      $display("FAIL abort_we_now: got %b want 0", we); end
    tick();
    i_abort = 1'b0;
    #1;
    tests++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tidx !== 5'd31) begin fails++;
      $display("FAIL abort_trace: got we=%b busy=%b done=%b t=%0d want 0 0 0 31",
               we, busy, done, tidx); end
    tick();
    i_chain_vld = 1'b0;
    tests++; if (done !== 1'b0) begin fails++;
      $display("FAIL abort_trace_after: got done=%b want 0", done); end
  endtask

  task automatic test_reset_mid_trace;
    start(5'd2, 5'd2);
    i_cell_rdy = 1'b1;
    repeat (4) tick();
    i_cell_rdy = 1'b0;
    tick();
    i_chain_vld = 1'b1;
    i_bus = mk(5'd1, 5'd1, 16'd3);
    tick();
    i_bus = mk(5'd0, 5'd1, 16'd2);
    #2;
    nrst = 1'b0;
    #1;
    tests++; if ({we, busy, cell_vld, outena, done, err} !== 6'b0) begin fails++;
      $display("FAIL rst_trace_flags: got %b want 000000", {we, busy, cell_vld, outena, done, err}); end
    tests++; if (tidx !== 5'd31 || ridx !== 5'd31 || addr !== 6'd0 || len !== 7'd0) begin fails++;
      $display("FAIL rst_trace_vals: got %0d,%0d a=%0d len=%0d want 31,31 0 0", tidx, ridx, addr, len); end
    i_chain_vld = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_illegal_start;
    start(5'd0, 5'd3);
    tests++; if (done !== 1'b1 || err !== 1'b1 || cell_vld !== 1'b0) begin fails++;
      $display("FAIL illegal_tlen0: got done=%b err=%b vld=%b want 1 1 0", done, err, cell_vld); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || cell_vld !== 1'b0) begin fails++;
      $display("FAIL illegal_after: got done=%b busy=%b err=%b vld=%b want 0 0 1 0",
               done, busy, err, cell_vld); end
    start(5'd4, 5'd31);
    tests++; if (done !== 1'b1 || err !== 1'b1 || cell_vld !== 1'b0) begin fails++;
      $display("FAIL illegal_rlen31: got done=%b err=%b vld=%b want 1 1 0", done, err, cell_vld); end
    tick();
  endtask

  task automatic test_busy_start;
    logic [4:0] et [4];
    logic [4:0] er [4];
    et = '{0, 0, 1, 1};
    er = '{0, 1, 0, 1};
    start(5'd2, 5'd2);
    tests++; if (err !== 1'b0) begin fails++;
      $display("FAIL busy_err_clear: got %b want 0", err); end
    i_cell_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        i_start = 1'b1; i_tlen = 5'd3; i_rlen = 5'd3;
      end else begin
        i_start = 1'b0;
      end
      tests++; if (cell_vld !== 1'b1 || tidx !== et[i] || ridx !== er[i]) begin fails++;
        $display("FAIL busy_cell%0d: got vld=%b %0d,%0d want 1 %0d,%0d",
                 i, cell_vld, tidx, ridx, et[i], er[i]); end
      tick();
    end
    i_start = 1'b0;
    i_cell_rdy = 1'b0;
    tests++; if (cell_vld !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL busy_drain: got vld=%b busy=%b want 0 1", cell_vld, busy); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_diag();
    test_backpressure();
    test_broken_chain();
    test_overflow();
    test_abort();
    test_diag();
    test_reset_mid_trace();
    test_illegal_start();
    test_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dtw_trace_ctrl.md
# dtw_trace_ctrl

Sequencer for the DTW score-unit array. It sweeps the (template, reference) cell indices broadcast to every score unit during the fill phase, then kicks the traceback chain at the final cell. It streams each word the array drives onto the shared path bus into SRAM until cell (0,0) is reached. It sits between the host start/done interface, the distance datapath, the score-unit array and the result SRAM.

## Interface
- `ADDR_W`, default 6: SRAM address width; path-buffer depth is 2^ADDR_W words.
- `IDX_INV`, default 5'd31: index value broadcast when no cell is active.
- `clk`, input, 1: clock.
- `nrst`, input, 1: reset, asynchronous, active-low.
- `i_start`, input, 1: one-cycle start pulse; ignored unless in IDLE.
- `i_abort`, input, 1: synchronous abort; returns to IDLE from any state.
- `i_tlen`, input, 5: template length, 1..30; sampled on accepted start.
- `i_rlen`, input, 5: reference length, 1..30; sampled on accepted start.
- `o_cell_vld`, output, 1: current index pair valid to the datapath.
- `i_cell_rdy`, input, 1: datapath has produced D and path for the current cell.
- `o_tindex`, output, 5: broadcast template index.
- `o_rindex`, output, 5: broadcast reference index.
- `o_outena_last`, output, 1: traceback kick to the unit at (tlen-1, rlen-1).
- `i_chain_vld`, input, 1: wired-OR of all score-unit output enables, including the kick; means the bus is driven.
- `i_bus`, input, 32: path bus. Bits [28:24] are tindex, [20:16] are rindex, [15:0] are D.
- `o_sram_we`, output, 1: SRAM write strobe.
- `o_sram_addr`, output, ADDR_W: SRAM write address.
- `o_sram_wdata`, output, 32: SRAM write data, equal to `i_bus`.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_done`, output, 1: one-cycle completion pulse.
- `o_err`, output, 1: error flag; valid with `o_done` and held until the next accepted start.
- `o_len`, output, ADDR_W+1: number of words written in the last run.

## Operation
- States: IDLE, FILL, DRAIN, KICK, TRACE, FIN.
- **IDLE:** `o_tindex` and `o_rindex` are IDX_INV, `o_cell_vld` is 0. On `i_start`:
  - latch tlen/rlen;
  - clear addr, `o_len` and `o_err`;
  - set t=0, r=0;
  - go to FILL.
- **FILL:** `o_cell_vld`=1, driving `o_tindex`=t and `o_rindex`=r.
  - On `o_cell_vld & i_cell_rdy`, advance row-major with r inner: r++; when r=rlen-1, wrap r to 0 and t++.
  - Acceptance of (tlen-1, rlen-1) moves the FSM to DRAIN.
  - Indices hold while `i_cell_rdy` is low.
- **DRAIN:** one cycle with indices at IDX_INV, so the final unit captures its result. Then go to KICK.
- **KICK:** `o_outena_last`=1 for exactly one cycle. Go to TRACE. The word on the bus this cycle is processed with the TRACE rules below.
- **TRACE (and the KICK cycle):** in each cycle with `i_chain_vld`=1:
  - assert `o_sram_we`, write `i_bus` at addr, then increment addr and `o_len`;
  - if the word has tindex=0 and rindex=0, go to FIN;
  - if the write was to the last address (addr = 2^ADDR_W−1) and the word is not (0,0), set `o_err` and go to FIN.
- **Broken chain:** in TRACE, a cycle with `i_chain_vld`=0 sets `o_err` and goes to FIN. There is no write that cycle.
- **FIN:** `o_done`=1 for one cycle, then IDLE.
- `i_abort` in any state: go to IDLE next cycle with no `o_done`; `o_sram_we` deasserts immediately. `i_abort` has priority over `i_start` and over every transition.
- `i_start` in a non-IDLE state is ignored.
- Lengths of 0 or 31 are illegal: on start, set `o_err`, pulse `o_done` the next cycle, and perform no fill.

## Timing
- Reset values:
  - state IDLE;
  - `o_tindex` and `o_rindex` = IDX_INV;
  - `o_cell_vld`, `o_outena_last`, `o_sram_we`, `o_done` and `o_err` = 0;
  - `o_sram_addr` = 0, `o_len` = 0.
- All outputs are registered except `o_sram_we`, `o_sram_addr` and `o_sram_wdata`. These are combinational from the state, `i_chain_vld` and the addr register, because the bus word is valid only in its drive cycle.
- Start to first `o_cell_vld` is 1 cycle.
- Fill with `i_cell_rdy` tied high takes tlen·rlen cycles.
- Last cell accepted → DRAIN is 1 cycle → KICK, so the first SRAM write happens 2 cycles after the last acceptance.
- Traceback writes one word per cycle. A path of P cells gives P consecutive writes, and `o_done` follows 1 cycle after the last write.
- Maximum P is tlen+rlen−1 = 59, which is below the 64-word depth at the default ADDR_W.

## Test plan
- **2x2, straight diagonal path.** tlen=rlen=2, rdy=1. Expect:
  - indices (0,0),(0,1),(1,0),(1,1), then DRAIN, then KICK;
  - bus words for (1,1) then (0,0) written at addr 0 and 1;
  - `o_done` one cycle later with `o_len`=2 and `o_err`=0.
- **Backpressure.** tlen=3, rlen=4, `i_cell_rdy` toggling 1,0,0,1,… Expect indices to hold during rdy=0 and all 12 cells presented exactly once, in row-major order.
- **Broken chain.** 3x3 fill; drop `i_chain_vld` on the third trace cycle while the bus word is (1,1). Expect 2 writes, `o_err`=1, `o_done` pulse and `o_len`=2.
- **Overflow.** ADDR_W=2; trace a 5-cell path. Expect 4 writes at addr 0..3, then `o_err`=1 and `o_done`.
- **Abort.** Assert `i_abort` mid-FILL, and separately mid-TRACE. Expect IDLE next cycle, indices at 31, no `o_done`, and no further writes. A following start runs cleanly.
- **Reset and illegal start.**
  - Assert nrst mid-TRACE: all outputs return to their reset values asynchronously.
  - Start with tlen=0: expect `o_err`=1 and `o_done` one cycle later, with no `o_cell_vld`.
  - Start while busy: ignored.
